// File: rtl/config_frame_loader_pkg.sv
// Shared types and constants for the configuration frame loader.
// Frame layout: sync byte, payload bytes (LSB first), then an XOR checksum byte.
package config_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    COMMIT
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  function automatic int num_bytes(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/config_frame_loader_if.sv
// Byte-stream port into the configuration loader.
// Handshake: a byte transfers on a rising clock edge where DataValid && DataReady;
// a source holding DataValid must keep DataIn stable until that edge.
interface config_frame_loader_if;
  logic [7:0] DataIn;
  logic       DataValid;
  logic       DataReady;

  modport master (output DataIn, output DataValid, input DataReady);
  modport slave  (input DataIn, input DataValid, output DataReady);
endinterface

// File: rtl/config_frame_loader.sv
// Frame loader: sync detect, shadow payload assembly, XOR checksum check and
// atomic commit of the shadow into ConfigBits.
module config_frame_loader
  import config_loader_pkg::*;
#(
  parameter int         NoConfigBits = 4,
  parameter logic [7:0] SyncByte     = SYNC_BYTE
) (
  input  logic                    CLK,
  input  logic                    resetn,
  config_frame_loader_if.slave    s_cfg,
  output logic [NoConfigBits-1:0] ConfigBits,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Error,
  output state_t                  DbgState
);

  localparam int NumBytes = num_bytes(NoConfigBits);
  localparam int CntW     = $clog2(NumBytes + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumBytes - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_accept;
  logic                    w_start;
  logic                    w_load;
  logic                    w_fail;
  logic                    w_commit;
  logic [CntW-1:0]         r_cnt;
  logic [7:0]              r_xor;
  logic [NoConfigBits-1:0] r_shadow;
  logic [NoConfigBits-1:0] w_shadow_upd;

  assign s_cfg.DataReady = (r_state != COMMIT);
  assign w_accept        = s_cfg.DataValid && s_cfg.DataReady;
  assign DbgState        = r_state;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_load   = 1'b0;
    w_fail   = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && (s_cfg.DataIn == SyncByte)) begin
          w_start = 1'b1;
          w_next  = LOAD;
        end
      end
      LOAD: begin
        // A sync value here is ordinary payload; there is no resync.
        if (w_accept) begin
          w_load = 1'b1;
          if (r_cnt == LastCnt) w_next = CHECK;
        end
      end
      CHECK: begin
        if (w_accept) begin
          if (s_cfg.DataIn == r_xor) begin
            w_next = COMMIT;
          end else begin
            w_fail = 1'b1;
            w_next = IDLE;
          end
        end
      end
      COMMIT: begin
        w_commit = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Bits of the current byte beyond NoConfigBits fall off here but still feed the checksum.
  always_comb begin
    w_shadow_upd = r_shadow;
    for (int i = 0; i < NoConfigBits; i++) begin
      if ((i / 8) == int'(r_cnt)) w_shadow_upd[i] = s_cfg.DataIn[i % 8];
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_shadow   <= '0;
      r_xor      <= '0;
      r_cnt      <= '0;
      ConfigBits <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Error      <= 1'b0;
    end else begin
      Busy <= (w_next != IDLE);
      Done <= w_commit;
      if (w_start) begin
        r_shadow <= '0;
        r_xor    <= '0;
        r_cnt    <= '0;
        Error    <= 1'b0;
      end
      if (w_load) begin
        r_shadow <= w_shadow_upd;
        r_xor    <= r_xor ^ s_cfg.DataIn;
        r_cnt    <= r_cnt + 1'b1;
      end
      if (w_fail)   Error      <= 1'b1;
      if (w_commit) ConfigBits <= r_shadow;
    end
  end

endmodule

// File: tb/tb_config_frame_loader.sv
// Bench for config_frame_loader: a 4-bit and a 12-bit instance driven by directed
// and random byte streams, checked against a frame-level reference model.
module tb_config_frame_loader;
  import config_loader_pkg::*;

  localparam int W0 = 4;
  localparam int W1 = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  config_frame_loader_if if0 ();
  config_frame_loader_if if1 ();

  logic [W0-1:0] cfg0;
  logic [W1-1:0] cfg1;
  logic          busy0, busy1, done0, done1, err0, err1;
  state_t        st0, st1;

  config_frame_loader #(.NoConfigBits(W0)) u_dut0 (
    .CLK(clk), .resetn(resetn), .s_cfg(if0), .ConfigBits(cfg0),
    .Busy(busy0), .Done(done0), .Error(err0), .DbgState(st0)
  );

  config_frame_loader #(.NoConfigBits(W1)) u_dut1 (
    .CLK(clk), .resetn(resetn), .s_cfg(if1), .ConfigBits(cfg1),
    .Busy(busy1), .Done(done1), .Error(err1), .DbgState(st1)
  );

  // ---------------- reference model ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          inframe[2];
  logic [7:0]  fbuf[2][3];
  int          fn[2];
  logic        err_m[2];
  logic [63:0] cur_m[2];
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  longint      t_q0[$];
  longint      t_q1[$];

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      inframe[d] = 1'b0;
      fn[d]      = 0;
      err_m[d]   = 1'b0;
      cur_m[d]   = 64'd0;
    end
    exp_q0.delete(); exp_q1.delete();
    t_q0.delete();   t_q1.delete();
  endfunction

  // Commit becomes visible at the falling edge 1.5 cycles after the checksum edge.
  function automatic void push_exp(int d, logic [63:0] v);
    longint t = longint'($time) + 15;
    if (d == 0) begin exp_q0.push_back(v); t_q0.push_back(t); end
    else        begin exp_q1.push_back(v); t_q1.push_back(t); end
  endfunction

  function automatic void model_accept(int d, logic [7:0] b);
    int          nb = (d == 0) ? 1 : 2;
    int          w  = (d == 0) ? W0 : W1;
    logic [7:0]  x;
    logic [63:0] v;
    if (!inframe[d]) begin
      if (b == SYNC_BYTE) begin
        inframe[d] = 1'b1;
        fn[d]      = 0;
        err_m[d]   = 1'b0;
      end
    end else begin
      fbuf[d][fn[d]] = b;
      fn[d]++;
      if (fn[d] == nb + 1) begin
        x = 8'd0;
        v = 64'd0;
        for (int k = 0; k < nb; k++) begin
          x = x ^ fbuf[d][k];
          v = v | (64'(fbuf[d][k]) << (8 * k));
        end
        v = v & ((64'd1 << w) - 64'd1);
        if (x == fbuf[d][nb]) push_exp(d, v);
        else                  err_m[d] = 1'b1;
        inframe[d] = 1'b0;
      end
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  function automatic void mon(int d, logic done, logic err, logic busy, logic rdy,
                              logic [63:0] cfg);
    logic   pend = 1'b0;
    longint ft   = 0;
    longint now  = longint'($time);
    logic [63:0] fv = 64'd0;
    if (d == 0 && exp_q0.size() > 0) begin pend = 1'b1; ft = t_q0[0]; fv = exp_q0[0]; end
    if (d == 1 && exp_q1.size() > 0) begin pend = 1'b1; ft = t_q1[0]; fv = exp_q1[0]; end
    if (pend && ft == now) begin
      check($sformatf("done_pulse%0d", d), 64'(done), 64'd1);
      check($sformatf("config_commit%0d", d), cfg, fv);
      cur_m[d] = fv;
      if (d == 0) begin void'(exp_q0.pop_front()); void'(t_q0.pop_front()); end
      else        begin void'(exp_q1.pop_front()); void'(t_q1.pop_front()); end
    end else begin
      check($sformatf("done_idle%0d", d), 64'(done), 64'd0);
      check($sformatf("config_hold%0d", d), cfg, cur_m[d]);
    end
    check($sformatf("error%0d", d), 64'(err), 64'(err_m[d]));
    check($sformatf("busy%0d", d), 64'(busy), 64'(inframe[d] || (pend && ft > now)));
    check($sformatf("ready%0d", d), 64'(rdy), 64'(!(pend && (ft - 10) == now)));
  endfunction

  always @(negedge clk) begin
    mon(0, done0, err0, busy0, if0.DataReady, 64'(cfg0));
    mon(1, done1, err1, busy1, if1.DataReady, 64'(cfg1));
  end

  // ---------------- driver tasks ----------------
  task automatic send(int d, logic [7:0] b);
    bit   ok = 1'b0;
    logic r;
    @(negedge clk);
    if (d == 0) begin if0.DataIn = b; if0.DataValid = 1'b1; end
    else        begin if1.DataIn = b; if1.DataValid = 1'b1; end
    for (int k = 0; k < 20 && !ok; k++) begin
      r = (d == 0) ? if0.DataReady : if1.DataReady;
      @(posedge clk);
      if (r) begin
        model_accept(d, b);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout%0d: byte %0h not accepted, required within 20 cycles", d, b);
    end
  endtask

  task automatic idle(int d, int n);
    @(negedge clk);
    if (d == 0) if0.DataValid = 1'b0;
    else        if1.DataValid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #1;
    resetn        = 1'b0;
    if0.DataValid = 1'b0;
    if1.DataValid = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic rand_frame(int d);
    int         nb = (d == 0) ? 1 : 2;
    logic [7:0] x  = 8'd0;
    logic [7:0] p;
    int         ng = $urandom_range(0, 2);
    for (int g = 0; g < ng; g++) begin
      p = 8'($urandom_range(0, 255));
      if (p == SYNC_BYTE) p = 8'h00;
      send(d, p);
    end
    if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(0, 2));
    send(d, SYNC_BYTE);
    for (int k = 0; k < nb; k++) begin
      p = 8'($urandom_range(0, 255));
      x = x ^ p;
      send(d, p);
      if ($urandom_range(0, 4) == 0) idle(d, $urandom_range(0, 3));
    end
    if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
    send(d, x);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetn        = 1'b0;
    if0.DataIn    = 8'h00;
    if0.DataValid = 1'b0;
    if1.DataIn    = 8'h00;
    if1.DataValid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    resetn = 1'b1;

    // 4-bit: basic, excess bits, bad checksum, garbage + held valid + back-to-back frames
    send(0, 8'hA5); send(0, 8'h0B); send(0, 8'h0B);
    idle(0, 3);
    send(0, 8'hA5); send(0, 8'hFB); send(0, 8'hFB);
    idle(0, 3);
    send(0, 8'hA5); send(0, 8'h05); send(0, 8'h07);
    idle(0, 2);
    send(0, 8'h00); send(0, 8'h3C);
    send(0, 8'hA5); send(0, 8'h03); send(0, 8'h03);
    send(0, 8'hA5); send(0, 8'h09); send(0, 8'h09);
    idle(0, 3);

    // 12-bit: multi-byte payload, payload bytes equal to sync
    send(1, 8'hA5); send(1, 8'h34); send(1, 8'h12); send(1, 8'h26);
    idle(1, 3);
    send(1, 8'hA5); send(1, 8'hA5); send(1, 8'hA5); send(1, 8'h00);
    idle(1, 3);

    // Reset mid-frame drops the partial frame; following bytes are not a sync
    send(0, 8'hA5);
    reset_dut();
    send(0, 8'h0B); send(0, 8'h0B);
    idle(0, 3);

    fork
      begin
        for (int f = 0; f < 40; f++) rand_frame(0);
        idle(0, 2);
      end
      begin
        for (int f = 0; f < 40; f++) rand_frame(1);
        idle(1, 2);
      end
    join

    repeat (5) @(negedge clk);
    check("drain0", 64'(exp_q0.size()), 64'd0);
    check("drain1", 64'(exp_q1.size()), 64'd0);
    check("final_state0", 64'(st0), 64'(IDLE));
    check("final_state1", 64'(st1), 64'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required to finish by t=500000");
    $fatal(1);
  end

endmodule
